// File: rtl/sequential_memory_master.sv
// Initiator for the 16-entry sequential memory: streams upstream words into
// memory in order and streams them back out through a one-entry output buffer.
module sequential_memory_master #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  input  logic                  out_ready,
  output logic                  mem_request_write,
  output logic                  mem_request_read,
  output logic [DATA_WIDTH-1:0] mem_data_in,
  input  logic                  mem_correct_read,
  input  logic [DATA_WIDTH-1:0] mem_data_out,
  output logic                  writes_done,
  output logic                  reads_done,
  output logic [2:0]            dbg_state
);

  // Handshakes: a word moves on either stream only in a cycle where valid
  // and ready are both high; valid never waits on ready, and a raised
  // out_valid holds out_data stable until it is consumed.

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    WR_PULSE   = 3'd1,
    WR_GAP     = 3'd2,
    RD_PULSE   = 3'd3,
    RD_CAPTURE = 3'd4
  } state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         wr_count_q, wr_count_d;
  logic [CW-1:0]         rd_count_q, rd_count_d;
  logic                  last_op_q, last_op_d;
  logic                  req_wr_q, req_wr_d;
  logic                  req_rd_q, req_rd_d;
  logic [DATA_WIDTH-1:0] mem_data_in_q, mem_data_in_d;
  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;

  logic can_wr, can_rd, grant_wr, grant_rd;

  // last_op_q: 0 = write, 1 = read; on contention the other operation wins.
  always_comb begin
    can_wr   = in_valid && (wr_count_q < DEPTH_C);
    can_rd   = (rd_count_q < wr_count_q) && mem_correct_read && !out_valid_q;
    grant_wr = 1'b0;
    grant_rd = 1'b0;
    if (state_q == IDLE && rd_count_q != DEPTH_C) begin
      if (can_wr && can_rd) begin
        grant_wr = last_op_q;
        grant_rd = !last_op_q;
      end else begin
        grant_wr = can_wr;
        grant_rd = can_rd;
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    wr_count_d    = wr_count_q;
    rd_count_d    = rd_count_q;
    last_op_d     = last_op_q;
    req_wr_d      = 1'b0;
    req_rd_d      = 1'b0;
    mem_data_in_d = mem_data_in_q;
    out_valid_d   = out_valid_q;
    out_data_d    = out_data_q;

    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    unique case (state_q)
      IDLE: begin
        if (grant_wr) begin
          mem_data_in_d = in_data;
          req_wr_d      = 1'b1;
          state_d       = WR_PULSE;
        end else if (grant_rd) begin
          req_rd_d = 1'b1;
          state_d  = RD_PULSE;
        end
      end
      WR_PULSE: begin
        if (wr_count_q < DEPTH_C) wr_count_d = wr_count_q + 1'b1;
        last_op_d = 1'b0;
        state_d   = WR_GAP;
      end
      WR_GAP: begin
        state_d = IDLE;
      end
      RD_PULSE: begin
        if (rd_count_q < wr_count_q) rd_count_d = rd_count_q + 1'b1;
        last_op_d = 1'b1;
        state_d   = RD_CAPTURE;
      end
      RD_CAPTURE: begin
        // memory updated data_out on the previous edge; it is stable now
        out_data_d  = mem_data_out;
        out_valid_d = 1'b1;
        state_d     = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      wr_count_q    <= '0;
      rd_count_q    <= '0;
      last_op_q     <= 1'b0;
      req_wr_q      <= 1'b0;
      req_rd_q      <= 1'b0;
      mem_data_in_q <= '0;
      out_valid_q   <= 1'b0;
      out_data_q    <= '0;
    end else begin
      state_q       <= state_d;
      wr_count_q    <= wr_count_d;
      rd_count_q    <= rd_count_d;
      last_op_q     <= last_op_d;
      req_wr_q      <= req_wr_d;
      req_rd_q      <= req_rd_d;
      mem_data_in_q <= mem_data_in_d;
      out_valid_q   <= out_valid_d;
      out_data_q    <= out_data_d;
    end
  end

  assign in_ready          = grant_wr;
  assign writes_done       = (wr_count_q == DEPTH_C);
  assign reads_done        = (rd_count_q == DEPTH_C);
  assign mem_request_write = req_wr_q;
  assign mem_request_read  = req_rd_q;
  assign mem_data_in       = mem_data_in_q;
  assign out_valid         = out_valid_q;
  assign out_data          = out_data_q;
  assign dbg_state         = state_q;

endmodule

// File: tb/tb_sequential_memory_master.sv
// Directed bench for sequential_memory_master with a behavioural model of the
// 16-entry pulse-driven memory and an in-order output scoreboard.
module tb_sequential_memory_master;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         in_valid = 1'b0;
  logic [W-1:0] in_data = '0;
  logic         in_ready;
  logic         out_valid;
  logic [W-1:0] out_data;
  logic         out_ready = 1'b0;
  logic         mem_request_write, mem_request_read;
  logic [W-1:0] mem_data_in;
  logic         mem_correct_read;
  logic [W-1:0] mem_data_out;
  logic         writes_done, reads_done;
  logic [2:0]   dbg_state;

  int tests_run = 0;
  int tests_failed = 0;
  int wr_pulses = 0;
  int rd_pulses = 0;
  int acc_cnt = 0;
  bit pulse_log[$];
  logic [W-1:0] exp_q[$];

  sequential_memory_master #(.DATA_WIDTH(W), .DEPTH(16)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .mem_request_write(mem_request_write), .mem_request_read(mem_request_read),
    .mem_data_in(mem_data_in), .mem_correct_read(mem_correct_read),
    .mem_data_out(mem_data_out),
    .writes_done(writes_done), .reads_done(reads_done), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  // memory model: acts on the rising edge of each request pulse
  logic [W-1:0] m_mem [16];
  logic [4:0]   m_wr, m_rd;
  logic         m_prev_w, m_prev_r;
  always @(posedge clk) begin
    if (reset) begin
      m_wr <= '0; m_rd <= '0; m_prev_w <= 1'b0; m_prev_r <= 1'b0;
      mem_data_out <= '0;
    end else begin
      m_prev_w <= mem_request_write;
      m_prev_r <= mem_request_read;
      if (mem_request_write && !m_prev_w && m_wr < 5'd16) begin
        m_mem[m_wr[3:0]] <= mem_data_in;
        m_wr <= m_wr + 5'd1;
      end
      if (mem_request_read && !m_prev_r && m_rd < m_wr) begin
        mem_data_out <= m_mem[m_rd[3:0]];
        m_rd <= m_rd + 5'd1;
      end
    end
  end
  assign mem_correct_read = (m_rd < m_wr);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // monitor / scoreboard
  logic mon_prev_w = 1'b0, mon_prev_r = 1'b0;
  always @(negedge clk) begin
    if (reset) begin
      mon_prev_w <= 1'b0;
      mon_prev_r <= 1'b0;
    end else begin
      if (mem_request_write || mem_request_read) begin
        check("req_overlap", {31'd0, mem_request_write & mem_request_read}, 0);
        check("req_gap", {31'd0, (mem_request_write & (mon_prev_w | mon_prev_r)) |
                                 (mem_request_read & (mon_prev_w | mon_prev_r))}, 0);
      end
      if (mem_request_write && !mon_prev_w) begin wr_pulses++; pulse_log.push_back(1'b0); end
      if (mem_request_read && !mon_prev_r) begin rd_pulses++; pulse_log.push_back(1'b1); end
      if (in_valid && in_ready) acc_cnt++;
      if (out_valid && out_ready) begin
        check("out_pending", {31'd0, exp_q.size() != 0}, 1);
        if (exp_q.size() != 0) check("out_data", {24'd0, out_data}, {24'd0, exp_q.pop_front()});
      end
      mon_prev_w <= mem_request_write;
      mon_prev_r <= mem_request_read;
    end
  end

  // driver tasks
  task automatic do_reset();
    reset = 1'b1; in_valid = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check("rst_state", {29'd0, dbg_state}, 0);
    check("rst_outs", {26'd0, in_ready, out_valid, mem_request_write, mem_request_read,
                       writes_done, reads_done}, 0);
    check("rst_data", {16'd0, out_data, mem_data_in}, 0);
    exp_q.delete(); pulse_log.delete();
    wr_pulses = 0; rd_pulses = 0; acc_cnt = 0;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic send_word(input logic [W-1:0] d);
    bit ok = 1'b0;
    in_valid = 1'b1; in_data = d;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1'b1; break; end
    end
    check("send_accept", {31'd0, ok}, 1);
    @(posedge clk); #1;
  endtask

  task automatic drain();
    for (int n = 0; n < 400 && (exp_q.size() != 0 || out_valid); n++) @(negedge clk);
    check("drain", exp_q.size(), 0);
    @(posedge clk); #1;
  endtask

  initial begin
    int lat;
    bit found;
    int rd_before;

    // basic round trip
    do_reset();
    out_ready = 1'b1;
    exp_q.push_back(8'h11); exp_q.push_back(8'h22); exp_q.push_back(8'h33);
    send_word(8'h11); in_valid = 1'b0;
    send_word(8'h22); in_valid = 1'b0;
    send_word(8'h33); in_valid = 1'b0;
    drain();
    check("rt_wr_pulses", wr_pulses, 3);
    check("rt_rd_pulses", rd_pulses, 3);

    // fill: 16 accepted, words 16..19 refused
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      exp_q.push_back(W'(i));
      send_word(W'(i));
    end
    for (int i = 16; i < 20; i++) begin
      in_data = W'(i);
      repeat (20) @(posedge clk);
    end
    @(negedge clk);
    check("fill_in_ready", {31'd0, in_ready}, 0);
    check("fill_accepted", acc_cnt, 16);
    check("fill_wr_pulses", wr_pulses, 16);
    check("fill_writes_done", {31'd0, writes_done}, 1);
    in_valid = 1'b0;
    drain();
    check("fill_rd_pulses", rd_pulses, 16);
    check("fill_reads_done", {31'd0, reads_done}, 1);
    check("fill_idle", {29'd0, dbg_state}, 0);

    // read stall when caught up
    do_reset();
    out_ready = 1'b1;
    exp_q.push_back(8'h01);
    send_word(8'h01); in_valid = 1'b0;
    drain();
    repeat (10) @(posedge clk);
    check("stall_rd_pulses", rd_pulses, 1);
    exp_q.push_back(8'hAA);
    send_word(8'hAA); in_valid = 1'b0;
    drain();
    check("stall_rd_after", rd_pulses, 2);

    // arbitration: strict W R W R ...
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(W'(8'hC0 + i));
      send_word(W'(8'hC0 + i));
    end
    in_valid = 1'b0;
    drain();
    check("arb_log_size", pulse_log.size(), 8);
    for (int i = 0; i < pulse_log.size(); i++)
      check("arb_alternate", {31'd0, pulse_log[i]}, i % 2);

    // backpressure
    do_reset();
    out_ready = 1'b0;
    exp_q.push_back(8'h5A); exp_q.push_back(8'h5B);
    send_word(8'h5A);
    send_word(8'h5B); in_valid = 1'b0;
    for (int n = 0; n < 40 && !out_valid; n++) @(negedge clk);
    @(negedge clk);
    check("bp_valid", {31'd0, out_valid}, 1);
    rd_before = rd_pulses;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_hold", {23'd0, out_valid, out_data}, {23'd0, 1'b1, 8'h5A});
    end
    check("bp_no_read", rd_pulses, rd_before);
    @(posedge clk); #1;
    out_ready = 1'b1;
    lat = 0; found = 1'b0;
    @(negedge clk);
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      lat++;
      if (out_valid && out_data == 8'h5B) begin found = 1'b1; break; end
    end
    check("bp_next_found", {31'd0, found}, 1);
    check("bp_latency_ge3", {31'd0, lat >= 3}, 1);
    drain();

    // reset during WR_PULSE
    do_reset();
    out_ready = 1'b1;
    in_valid = 1'b1; in_data = 8'h99;
    for (int n = 0; n < 10 && !in_ready; n++) @(negedge clk);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("mid_wr_pulse", {31'd0, mem_request_write}, 1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("mid_rst_outs", {26'd0, in_ready, out_valid, mem_request_write, mem_request_read,
                           writes_done, reads_done}, 0);
    check("mid_rst_data", {16'd0, out_data, mem_data_in}, 0);
    check("mid_rst_state", {29'd0, dbg_state}, 0);
    @(posedge clk); #1;
    exp_q.push_back(8'h7E);
    send_word(8'h7E); in_valid = 1'b0;
    drain();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
